// File: rtl/stream_pkg.sv
// Shared types and reference reorder for the stream slice packer.
// Optional flush port of the packer is enabled by STREAM_PACK_FLUSH_EN.
package stream_pkg;

  typedef enum logic {
    STREAM_DIR_RIGHT = 1'b0,
    STREAM_DIR_LEFT  = 1'b1
  } stream_dir_e;

  localparam int STREAM_MAX_W = 256;

  typedef logic [STREAM_MAX_W-1:0] stream_word_t;

  // Reference {<< slice {w}} on the low 'width' bits of w.
  function automatic stream_word_t slice_reverse(
    input stream_word_t w,
    input int           width,
    input int           slice
  );
    stream_word_t r;
    int           lo;
    int           len;
    int           hi;
    r = '0;
    for (int j = 0; j < STREAM_MAX_W; j++) begin
      lo = j * slice;
      if (slice > 0 && lo < width) begin
        len = (width - lo < slice) ? width - lo : slice;
        hi  = width - 1 - lo;
        for (int b = 0; b < STREAM_MAX_W; b++) begin
          if (b < len) r[hi - len + 1 + b] = w[lo + b];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_slice_reverse.sv
// Combinational slice reversal: chunks taken from the LSB are
// emitted from the MSB down; a short final chunk lands at the LSB.
import stream_pkg::*;

module stream_slice_reverse #(
  parameter int W     = 32,
  parameter int SLICE = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int NC = (W + SLICE - 1) / SLICE;

  // One chunk move per generate iteration.
  for (genvar j = 0; j < NC; j++) begin : g_chunk
    localparam int LO  = j * SLICE;
    localparam int LEN = (W - LO < SLICE) ? W - LO : SLICE;
    localparam int HI  = W - 1 - LO;
    assign dout[HI -: LEN] = din[LO +: LEN];
  end

endmodule

// File: rtl/stream_slice_packer.sv
// Packs BEATS input beats into one word, optionally slice-reversed.
// STREAM_PACK_FLUSH_EN adds a flush port that emits a zero-padded word.
import stream_pkg::*;

module stream_slice_packer #(
  parameter int IN_W  = 8,
  parameter int BEATS = 4,
  parameter int SLICE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef STREAM_PACK_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [IN_W*BEATS-1:0] out_data
);

  localparam int OUT_W = IN_W * BEATS;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_LAST = 1'b1
  } state_e;

  state_e             state;
  logic [CNT_W-1:0]   count;
  logic [OUT_W-1:0]   acc;
  stream_dir_e        dir_q;

  logic [OUT_W-1:0]   acc_ins;
  logic [OUT_W-1:0]   word;
  logic [OUT_W-1:0]   rev_word;
  logic [OUT_W-1:0]   next_out;
  stream_dir_e        dir_eff;
  logic               can_load;
  logic               accept;
  logic               last;
  logic               flush_go;
  logic               emit;

  assign can_load = !out_valid || out_ready;
  assign in_ready = (state != ST_LAST) || can_load;
  assign accept   = in_valid && in_ready;
  assign last     = accept && (state == ST_LAST);

`ifdef STREAM_PACK_FLUSH_EN
  assign flush_go = flush && can_load &&
                    ((count != '0) || accept);
`else
  assign flush_go = 1'b0;
`endif

  assign emit = last || flush_go;

  // Place the current beat into its slot and pick the word direction.
  always_comb begin
    acc_ins = acc;
    acc_ins[(BEATS - 1 - int'(count)) * IN_W +: IN_W] = in_data;
    word    = accept ? acc_ins : acc;
    dir_eff = (count == '0) ? stream_dir_e'(in_dir) : dir_q;
    next_out = (dir_eff == STREAM_DIR_LEFT) ? rev_word : word;
  end

  stream_slice_reverse #(
    .W     (OUT_W),
    .SLICE (SLICE)
  ) u_rev (
    .din  (word),
    .dout (rev_word)
  );

  // Beat counter FSM, accumulator and registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      count     <= '0;
      acc       <= '0;
      dir_q     <= STREAM_DIR_RIGHT;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (emit) begin
        state     <= ST_FILL;
        count     <= '0;
        acc       <= '0;
        out_data  <= next_out;
        out_valid <= 1'b1;
      end else begin
        if (accept) begin
          count <= count + 1'b1;
          acc   <= acc_ins;
          state <= ((count + 1'b1) == CNT_LAST) ? ST_LAST : ST_FILL;
        end
        if (out_ready) out_valid <= 1'b0;
      end
      if (accept && (count == '0)) dir_q <= dir_eff;
    end
  end

endmodule

// File: tb/tb_stream_slice_packer.sv
// Randomized + directed bench for stream_slice_packer (SLICE 8, 1, 5).
// Exercises flush too when STREAM_PACK_FLUSH_EN is defined.
import stream_pkg::*;

module tb_stream_slice_packer;

  localparam int IN_W  = 8;
  localparam int BEATS = 4;
  localparam int OUT_W = 32;
  localparam int NI    = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [IN_W-1:0] in_data;
  logic in_dir;
  logic out_ready;
  logic flush_i;

  logic             in_ready_a [NI];
  logic             out_valid_a[NI];
  logic [OUT_W-1:0] out_data_a [NI];

  int slices[NI] = '{8, 1, 5};

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq[$];
  bit          mdir;
  bit          m_ov;
  logic [31:0] m_od[NI];

  always #5 clk = ~clk;

  stream_slice_packer #(.IN_W(8), .BEATS(4), .SLICE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid_a[0]), .out_ready(out_ready),
`ifdef STREAM_PACK_FLUSH_EN
    .flush(flush_i),
`endif
    .out_data(out_data_a[0])
  );

  stream_slice_packer #(.IN_W(8), .BEATS(4), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid_a[1]), .out_ready(out_ready),
`ifdef STREAM_PACK_FLUSH_EN
    .flush(flush_i),
`endif
    .out_data(out_data_a[1])
  );

  stream_slice_packer #(.IN_W(8), .BEATS(4), .SLICE(5)) u_s5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid_a[2]), .out_ready(out_ready),
`ifdef STREAM_PACK_FLUSH_EN
    .flush(flush_i),
`endif
    .out_data(out_data_a[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Chunks of s bits peeled from the LSB, stacked from the MSB down.
  function automatic logic [31:0] ref_reorder(input logic [31:0] w,
                                              input int s, input bit dir);
    logic [31:0] r;
    logic [31:0] chunk;
    int pos;
    int outpos;
    int len;
    if (!dir) return w;
    r = '0;
    pos = 0;
    outpos = 32;
    while (pos < 32) begin
      len = (32 - pos < s) ? 32 - pos : s;
      chunk = (w >> pos) & ((32'h1 << len) - 32'h1);
      if (len == 32) chunk = w;
      outpos -= len;
      r |= chunk << outpos;
      pos += len;
    end
    return r;
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit dir,
                      input bit ordy, input bit fl = 1'b0);
    bit m_rdy;
    bit acc;
    bit lst;
    bit fgo;
    logic [31:0] w;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("out_valid[%0d]", i), out_valid_a[i], m_ov);
      if (m_ov) chk($sformatf("out_data[%0d]", i), out_data_a[i], m_od[i]);
    end
    in_valid  = v;
    in_data   = d;
    in_dir    = dir;
    out_ready = ordy;
    flush_i   = fl;
    #1;
    m_rdy = !(mq.size() == BEATS - 1 && m_ov && !ordy);
    for (int i = 0; i < NI; i++)
      chk($sformatf("in_ready[%0d]", i), in_ready_a[i], m_rdy);
    acc = v && m_rdy;
    if (acc) begin
      if (mq.size() == 0) mdir = dir;
      mq.push_back(d);
    end
    lst = acc && mq.size() == BEATS;
`ifdef STREAM_PACK_FLUSH_EN
    fgo = fl && (!m_ov || ordy) && mq.size() > 0;
`else
    fgo = 1'b0;
`endif
    if (lst || fgo) begin
      w = '0;
      for (int k = 0; k < mq.size(); k++)
        w |= 32'(mq[k]) << (24 - 8 * k);
      for (int i = 0; i < NI; i++) m_od[i] = ref_reorder(w, slices[i], mdir);
      m_ov = 1'b1;
      mq.delete();
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 8'h00, 1'b0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush_i  = 1'b0;
    rst_n    = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", out_valid_a[i], 1'b0);
      chk("rst_out_data", out_data_a[i], 32'h0);
      chk("rst_in_ready", in_ready_a[i], 1'b1);
    end
    mq.delete();
    m_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    stream_word_t sw;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_dir = 1'b0;
    out_ready = 1'b0;
    flush_i = 1'b0;
    mdir = 1'b0;
    m_ov = 1'b0;
    for (int i = 0; i < NI; i++) m_od[i] = '0;
    do_reset();

    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    idle(1'b1);
    chk("t1_right", out_data_a[0], 32'h01020304);

    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b1, 1'b1);
    idle(1'b1);
    chk("t2_left_s8", out_data_a[0], 32'h04030201);

    for (int k = 0; k < 4; k++) step(1'b1, (k == 3) ? 8'h01 : 8'h00, 1'b1, 1'b1);
    idle(1'b1);
    chk("t2_left_s1", out_data_a[1], 32'h80000000);
    chk("t3_left_s5", out_data_a[2], 32'h08000000);

    for (int k = 4; k >= 1; k--) step(1'b1, 8'(k), 1'b1, 1'b1);
    idle(1'b1);
    sw = slice_reverse(stream_word_t'(32'h04030201), 32, 5);
    chk("t3_pkg_s5", out_data_a[2], sw[31:0]);

    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1);
    idle(1'b1);
    chk("dir_midpkt", out_data_a[0], 32'h11223344);

    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    for (int k = 5; k <= 7; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b1, 8'h08, 1'b0, 1'b0);
    chk("bp_stall", in_ready_a[0], 1'b0);
    step(1'b1, 8'h08, 1'b0, 1'b1);
    idle(1'b0);
    chk("bp_valid", out_valid_a[0], 1'b1);
    chk("bp_word", out_data_a[0], 32'h05060708);

    step(1'b1, 8'h09, 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h0A, 1'b0, 1'b1);
    step(1'b1, 8'h0B, 1'b0, 1'b1);
    step(1'b1, 8'h0C, 1'b0, 1'b1);
    step(1'b1, 8'h0D, 1'b0, 1'b1);
    idle(1'b1);
    chk("rst_resume", out_data_a[0], 32'h0A0B0C0D);

`ifdef STREAM_PACK_FLUSH_EN
    idle(1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("flush_right", out_data_a[0], 32'hAABB0000);
    step(1'b1, 8'hAA, 1'b1, 1'b1);
    step(1'b1, 8'hBB, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("flush_left", out_data_a[0], 32'h0000BBAA);
    idle(1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("flush_empty", out_valid_a[0], 1'b0);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) do_reset();
      step($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
